// File: rtl/dps_pkg.sv
// Shared types and defaults for the digital pixel sensor frame sequencer.
package dps_pkg;

    // Frame phases, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        TURN,
        READ,
        DONE
    } state_t;

    // Width of the shared pixel data bus.
    localparam int DATA_W = 32;

    // Default frame timing.
    localparam int DEF_ERASE_CYCLES = 5;
    localparam int DEF_EXPOSE_TIME  = 255;
    localparam int DEF_ADC_BITS     = 8;
    localparam int DEF_NUM_ROWS     = 2;

    // Largest of four values; sizes the shared phase counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dps_frame_sequencer_if.sv
// System / pixel-array control bundle of the frame sequencer.
// master = the sequencer, slave = the system and pixel array.
interface dps_frame_sequencer_if
    import dps_pkg::*;
#(
    parameter int ADC_BITS = DEF_ADC_BITS,
    parameter int NUM_ROWS = DEF_NUM_ROWS
);
    logic                start;
    logic                erase;
    logic                expose;
    logic                convert;
    logic [ADC_BITS-1:0] ramp;
    logic [NUM_ROWS-1:0] read_row;
    logic                busy;
    logic                frame_valid;

    modport master (
        input  start,
        output erase, expose, convert, ramp, read_row, busy, frame_valid
    );

    modport slave (
        output start,
        input  erase, expose, convert, ramp, read_row, busy, frame_valid
    );
endinterface

// File: rtl/dps_down_counter.sv
// Loadable down-counter that times every multi-cycle frame phase.
// It is loaded with (duration - 1) on phase entry; the zero flag marks the final cycle of the phase.
module dps_down_counter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_enable,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_count;

    // Load has priority; otherwise count down and hold at zero.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/dps_frame_sequencer.sv
// Frame sequencer for the digital pixel sensor array: erase, exposure, ADC ramp conversion,
// bus turnaround and one-hot row readout. Every pixel-facing output comes straight from a flop.
module dps_frame_sequencer
    import dps_pkg::*;
#(
    parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
    parameter int EXPOSE_TIME  = DEF_EXPOSE_TIME,
    parameter int ADC_BITS     = DEF_ADC_BITS,
    parameter int NUM_ROWS     = DEF_NUM_ROWS
) (
    input logic                   clk,
    input logic                   reset,
    dps_frame_sequencer_if.master bus
);
    localparam int RAMP_STEPS = 2 ** ADC_BITS;
    localparam int CNT_W      = $clog2(max4(ERASE_CYCLES, EXPOSE_TIME, RAMP_STEPS, NUM_ROWS) + 1);

    // Zero-length phases would break the one-cycle-per-step timing, so refuse them at elaboration.
    generate
        if (ERASE_CYCLES < 1 || EXPOSE_TIME < 1 || NUM_ROWS < 1) begin : g_bad_params
            $error("dps_frame_sequencer: ERASE_CYCLES, EXPOSE_TIME and NUM_ROWS must all be >= 1");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_next;
    logic                w_load;
    logic [CNT_W-1:0]    w_load_value;
    logic                w_count_en;
    logic                w_cnt_zero;

    logic                r_erase;
    logic                r_expose;
    logic                r_convert;
    logic [ADC_BITS-1:0] r_ramp;
    logic [NUM_ROWS-1:0] r_read_row;
    logic                r_busy;
    logic                r_frame_valid;

    dps_down_counter #(.WIDTH(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_value  (w_load_value),
        .i_enable (w_count_en),
        .o_zero   (w_cnt_zero)
    );

    // State register; reset returns to IDLE immediately, aborting any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: start is looked at only in IDLE and DONE, so requests mid-frame are dropped.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start)  w_state_next = ERASE;
            ERASE:   if (w_cnt_zero) w_state_next = EXPOSE;
            EXPOSE:  if (w_cnt_zero) w_state_next = CONVERT;
            CONVERT: if (w_cnt_zero) w_state_next = TURN;
            TURN:                    w_state_next = READ;
            READ:    if (w_cnt_zero) w_state_next = DONE;
            DONE:    w_state_next = bus.start ? ERASE : IDLE;
            default:                 w_state_next = IDLE;
        endcase
    end

    // Phase counter loads (duration - 1) whenever a new state is entered.
    always_comb begin
        w_load       = (w_state_next != r_state);
        w_count_en   = (r_state != IDLE);
        w_load_value = '0;
        case (w_state_next)
            ERASE:   w_load_value = CNT_W'(ERASE_CYCLES - 1);
            EXPOSE:  w_load_value = CNT_W'(EXPOSE_TIME - 1);
            CONVERT: w_load_value = CNT_W'(RAMP_STEPS - 1);
            READ:    w_load_value = CNT_W'(NUM_ROWS - 1);
            default: w_load_value = '0;
        endcase
    end

    // Outputs decoded from the next state into flops, so each pin is aligned with its state
    // and reset clears read_row at once, releasing the data bus without a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_erase       <= 1'b0;
            r_expose      <= 1'b0;
            r_convert     <= 1'b0;
            r_ramp        <= '0;
            r_read_row    <= '0;
            r_busy        <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            r_erase       <= (w_state_next == ERASE);
            r_expose      <= (w_state_next == EXPOSE);
            r_convert     <= (w_state_next == CONVERT);
            r_busy        <= (w_state_next != IDLE);
            r_frame_valid <= (w_state_next == DONE);
            // Ramp restarts at 0 on CONVERT entry; the phase ends on the max code, so it never wraps.
            if (w_state_next == CONVERT && r_state == CONVERT) begin
                r_ramp <= r_ramp + 1'b1;
            end else begin
                r_ramp <= '0;
            end
            // Walk a single one-hot bit across the rows, one row per READ cycle.
            if (w_state_next == READ) begin
                r_read_row <= (r_state == READ) ? (r_read_row << 1) : NUM_ROWS'(1);
            end else begin
                r_read_row <= '0;
            end
        end
    end

    assign bus.erase       = r_erase;
    assign bus.expose      = r_expose;
    assign bus.convert     = r_convert;
    assign bus.ramp        = r_ramp;
    assign bus.read_row    = r_read_row;
    assign bus.busy        = r_busy;
    assign bus.frame_valid = r_frame_valid;
endmodule

// File: tb/tb_dps_frame_sequencer.sv
// Scoreboard bench for dps_frame_sequencer. Two instances share start/reset: A uses default
// timing, B the smallest legal timing (1/1/2/4). The stimulus side records when each
// instance should accept start; the monitor derives every expected output from the frame
// phase arithmetic and retires a frame record on each frame_valid.
module tb_dps_frame_sequencer;
    import dps_pkg::*;

    localparam int A_E = DEF_ERASE_CYCLES;
    localparam int A_X = DEF_EXPOSE_TIME;
    localparam int A_B = DEF_ADC_BITS;
    localparam int A_R = DEF_NUM_ROWS;
    localparam int B_E = 1;
    localparam int B_X = 1;
    localparam int B_B = 2;
    localparam int B_R = 4;

    // Cycles from the start-sampling cycle through the frame_valid cycle, inclusive.
    localparam int LEN_A = 1 + A_E + A_X + (1 << A_B) + 1 + A_R + 1;
    localparam int LEN_B = 1 + B_E + B_X + (1 << B_B) + 1 + B_R + 1;

    typedef struct packed {
        logic       erase;
        logic       expose;
        logic       convert;
        logic       busy;
        logic       fv;
        logic [7:0] ramp;
        logic [3:0] rows;
    } pix_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    int   cyc   = 0;

    int n_checks = 0;
    int n_pass   = 0;

    int   exp_q_a[$];
    int   exp_q_b[$];
    int   model_t0[2];
    pix_t obs_s[2];
    pix_t exp_s[2];

    logic [DATA_W-1:0] pix_data [A_R];
    logic [DATA_W-1:0] bus_data;
    int                bus_drivers;

    dps_frame_sequencer_if #(.ADC_BITS(A_B), .NUM_ROWS(A_R)) bus_a ();
    dps_frame_sequencer_if #(.ADC_BITS(B_B), .NUM_ROWS(B_R)) bus_b ();

    assign bus_a.start = start;
    assign bus_b.start = start;

    dps_frame_sequencer #(
        .ERASE_CYCLES(A_E), .EXPOSE_TIME(A_X), .ADC_BITS(A_B), .NUM_ROWS(A_R)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    dps_frame_sequencer #(
        .ERASE_CYCLES(B_E), .EXPOSE_TIME(B_X), .ADC_BITS(B_B), .NUM_ROWS(B_R)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared data bus of instance A: each row drives its word when its output enable is high.
    always_comb begin
        bus_data    = '0;
        bus_drivers = 0;
        for (int r = 0; r < A_R; r++) begin
            if (bus_a.read_row[r]) begin
                bus_data    = bus_data | pix_data[r];
                bus_drivers = bus_drivers + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic int flen(input int k);
        return (k == 0) ? LEN_A : LEN_B;
    endfunction

    // Reference: outputs d cycles after the start-sampling cycle of a frame.
    function automatic pix_t expect_at(input int k, input int d);
        pix_t p;
        int   e;
        int   x;
        int   c;
        int   r;
        p = '0;
        e = (k == 0) ? A_E : B_E;
        x = (k == 0) ? A_X : B_X;
        c = 1 << ((k == 0) ? A_B : B_B);
        r = (k == 0) ? A_R : B_R;
        if (d < 1 || d > e + x + c + r + 2) return p;
        p.busy = 1'b1;
        if (d <= e) begin
            p.erase = 1'b1;
        end else if (d <= e + x) begin
            p.expose = 1'b1;
        end else if (d <= e + x + c) begin
            p.convert = 1'b1;
            p.ramp    = 8'(d - e - x - 1);
        end else if (d == e + x + c + 1) begin
            p.busy = 1'b1;
        end else if (d <= e + x + c + 1 + r) begin
            p.rows = 4'(1 << (d - e - x - c - 2));
        end else begin
            p.fv = 1'b1;
        end
        return p;
    endfunction

    // One stimulus cycle; records a frame start for every instance that will sample start=1.
    task automatic step(input logic s);
        @(posedge clk);
        #1;
        start = s;
        if (s && reset) begin
            for (int k = 0; k < 2; k++) begin
                if (model_t0[k] < 0 || cyc >= model_t0[k] + flen(k) - 1) begin
                    model_t0[k] = cyc;
                    if (k == 0) exp_q_a.push_back(cyc);
                    else        exp_q_b.push_back(cyc);
                end
            end
        end
    endtask

    // Monitor: compare each instance every cycle on the falling edge, retire frames on frame_valid.
    always @(negedge clk) begin
        int   head;
        logic inv;
        logic [DATA_W-1:0] want_data;
        obs_s[0].erase   = bus_a.erase;
        obs_s[0].expose  = bus_a.expose;
        obs_s[0].convert = bus_a.convert;
        obs_s[0].busy    = bus_a.busy;
        obs_s[0].fv      = bus_a.frame_valid;
        obs_s[0].ramp    = 8'(bus_a.ramp);
        obs_s[0].rows    = 4'(bus_a.read_row);
        obs_s[1].erase   = bus_b.erase;
        obs_s[1].expose  = bus_b.expose;
        obs_s[1].convert = bus_b.convert;
        obs_s[1].busy    = bus_b.busy;
        obs_s[1].fv      = bus_b.frame_valid;
        obs_s[1].ramp    = 8'(bus_b.ramp);
        obs_s[1].rows    = 4'(bus_b.read_row);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) head = (exp_q_a.size() > 0) ? exp_q_a[0] : -1;
            else        head = (exp_q_b.size() > 0) ? exp_q_b[0] : -1;
            exp_s[k] = (reset && head >= 0) ? expect_at(k, cyc - head) : '0;
            check($sformatf("%s ctl cyc%0d", (k == 0) ? "A" : "B", cyc),
                  {obs_s[k].erase, obs_s[k].expose, obs_s[k].convert, obs_s[k].busy, obs_s[k].fv},
                  {exp_s[k].erase, exp_s[k].expose, exp_s[k].convert, exp_s[k].busy, exp_s[k].fv});
            check($sformatf("%s ramp cyc%0d", (k == 0) ? "A" : "B", cyc), obs_s[k].ramp, exp_s[k].ramp);
            check($sformatf("%s rows cyc%0d", (k == 0) ? "A" : "B", cyc), obs_s[k].rows, exp_s[k].rows);
            inv = ($countones({obs_s[k].erase, obs_s[k].expose, obs_s[k].convert, |obs_s[k].rows}) <= 1)
                  && $onehot0(obs_s[k].rows)
                  && (obs_s[k].convert || obs_s[k].ramp == 8'd0);
            check($sformatf("%s invariants cyc%0d", (k == 0) ? "A" : "B", cyc), inv, 1'b1);
            if (obs_s[k].fv) begin
                if (head < 0) begin
                    check($sformatf("%s unexpected frame_valid cyc%0d", (k == 0) ? "A" : "B", cyc),
                          obs_s[k].fv, 1'b0);
                end else begin
                    check($sformatf("%s frame end cycle", (k == 0) ? "A" : "B"), cyc, head + flen(k) - 1);
                    if (k == 0) void'(exp_q_a.pop_front());
                    else        void'(exp_q_b.pop_front());
                end
            end
        end
        want_data = '0;
        for (int r = 0; r < A_R; r++) begin
            if (exp_s[0].rows[r]) want_data = pix_data[r];
        end
        check($sformatf("A bus drivers cyc%0d", cyc), bus_drivers, (exp_s[0].rows != 4'd0) ? 1 : 0);
        check($sformatf("A bus data cyc%0d", cyc), bus_data, want_data);
    end

    initial begin
        model_t0 = '{-1, -1};
        for (int r = 0; r < A_R; r++) pix_data[r] = $urandom;

        // Reset held for a few edges, released mid-cycle.
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (4) step(1'b0);

        // Single frame from a one-cycle start pulse.
        step(1'b1);
        repeat (LEN_A + 2) step(1'b0);

        // Start pulses inside EXPOSE (d=105) and READ (d=519) must not disturb the frame.
        step(1'b1);
        for (int i = 1; i <= LEN_A + 2; i++) step(i == A_E + 100 || i == A_E + A_X + (1 << A_B) + 3);

        // start held through DONE: two back-to-back frames, then release.
        repeat (LEN_A) step(1'b1);
        repeat (LEN_A + 3) step(1'b0);

        // Reset asserted while row 0 drives the bus.
        step(1'b1);
        repeat (A_E + A_X + (1 << A_B) + 2) step(1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        exp_q_a.delete();
        exp_q_b.delete();
        model_t0 = '{-1, -1};
        #1;
        check("async read_row A", bus_a.read_row, 2'b00);
        check("async busy A", bus_a.busy, 1'b0);
        check("async read_row B", bus_b.read_row, 4'b0000);
        @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (2) step(1'b0);
        step(1'b1);
        repeat (LEN_A + 2) step(1'b0);

        // Randomized start traffic.
        repeat (1200) step($urandom_range(0, 15) == 0);
        repeat (LEN_A + 5) step(1'b0);

        check("A frames outstanding", exp_q_a.size(), 0);
        check("B frames outstanding", exp_q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
